// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one word fetch per cycle under a credit limit,
// and buffers returned instructions for the decoder through a valid/ready handshake.
module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [31:0]     i_imem_rdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_instr_pc,
    output logic [6:0]      o_opcode
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] buf_pc    [DEPTH];
    logic [31:0]     buf_instr [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;
    logic            squash;

    logic            pop;
    logic            push;
    logic [CW:0]     occupancy;
    logic            unused_redirect_lsb;

    // Target alignment discards the two low redirect bits.
    assign unused_redirect_lsb = ^i_redirect_pc[1:0];

    assign o_instr_valid = (count != '0) & ~i_redirect;
    assign pop           = o_instr_valid & i_instr_ready;
    assign push          = inflight & ~squash;

    // Slots already spoken for once this cycle's pop retires; a new request
    // is only issued when its response is guaranteed a free entry.
    assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign o_imem_req = ~i_rst & ~i_redirect & (occupancy < (CW+1)'(DEPTH));

    assign o_imem_addr = pc_q;
    assign o_instr     = buf_instr[rd_ptr];
    assign o_instr_pc  = buf_pc[rd_ptr];
    assign o_opcode    = o_instr[6:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q        <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            squash      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= '0;
            end
        end else if (i_redirect) begin
            pc_q     <= {i_redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            squash   <= inflight;
            inflight <= 1'b0;
        end else begin
            squash      <= 1'b0;
            inflight    <= o_imem_req;
            inflight_pc <= pc_q;
            if (o_imem_req) begin
                pc_q <= pc_q + XLEN'(4);
            end
            if (push) begin
                buf_pc[wr_ptr]    <= inflight_pc;
                buf_instr[wr_ptr] <= i_imem_rdata;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios pinned with literal values, then
// random traffic checked every cycle against a queue-based model of the fetch stage.
module tb_instr_fetch;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, redirect, ready;
    logic [31:0] redirect_pc;
    logic [31:0] rdata;
    logic        req, valid;
    logic [31:0] addr, instr, instr_pc;
    logic [6:0]  opcode;

    logic        ready2 = 1'b1;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = '0;
    logic [31:0] rdata2;
    logic        req2, valid2;
    logic [31:0] addr2, instr2, instr_pc2;
    logic [6:0]  opcode2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_rdata(rdata),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_instr_valid(valid), .i_instr_ready(ready),
        .o_instr(instr), .o_instr_pc(instr_pc), .o_opcode(opcode)
    );

    instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(req2), .o_imem_addr(addr2), .i_imem_rdata(rdata2),
        .i_redirect(redirect2), .i_redirect_pc(redirect_pc2),
        .o_instr_valid(valid2), .i_instr_ready(ready2),
        .o_instr(instr2), .o_instr_pc(instr_pc2), .o_opcode(opcode2)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h0000_0013 | (a << 20);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction memories: sample the request mid-cycle, answer one cycle later.
    logic        cap_req = 1'b0, cap_req2 = 1'b0;
    logic [31:0] cap_addr = '0, cap_addr2 = '0;

    always @(negedge clk) begin
        cap_req   = req;
        cap_addr  = addr;
        cap_req2  = req2;
        cap_addr2 = addr2;
    end

    initial begin
        rdata  = '0;
        rdata2 = '0;
        forever begin
            @(posedge clk);
            #1;
            rdata  = cap_req  ? word(cap_addr)  : $urandom();
            rdata2 = cap_req2 ? word(cap_addr2) : $urandom();
        end
    end

    // Reference model: buffered entries, the one outstanding fetch, the PC.
    ent_t        mq[$];
    bit          model_live = 0;
    bit          m_pend = 0;
    logic [31:0] m_pend_pc = '0;
    logic [31:0] m_pc = '0;
    bit          m_squash = 0;

    always @(negedge clk) begin
        bit   e_valid, e_pop, e_req;
        int   occ;
        ent_t e;
        e_valid = (mq.size() != 0) && !redirect;
        e_pop   = e_valid && ready;
        occ     = mq.size() + (m_pend ? 1 : 0) - (e_pop ? 1 : 0);
        e_req   = !rst && !redirect && (occ < DEPTH);
        if (model_live) begin
            chk("model req", {31'b0, req}, {31'b0, e_req});
            chk("model addr", addr, m_pc);
            chk("model valid", {31'b0, valid}, {31'b0, e_valid});
            if (e_valid) begin
                chk("model pc", instr_pc, mq[0].pc);
                chk("model instr", instr, mq[0].instr);
                chk("model opcode", {25'b0, opcode}, {25'b0, mq[0].instr[6:0]});
            end
        end
        if (rst) begin
            mq.delete();
            m_pend     = 0;
            m_pc       = 32'h0;
            m_squash   = 0;
            model_live = 1;
        end else if (model_live) begin
            if (redirect) begin
                mq.delete();
                m_squash = m_pend;
                m_pend   = 0;
                m_pc     = redirect_pc & ~32'h3;
            end else begin
                if (e_pop) void'(mq.pop_front());
                if (m_pend && !m_squash) begin
                    checks++;
                    if (mq.size() + (e_pop ? 1 : 0) >= DEPTH) begin
                        errors++;
                        $display("FAIL push_full: occupancy %0d at %0t", mq.size(), $time);
                    end
                    e.pc    = m_pend_pc;
                    e.instr = word(m_pend_pc);
                    mq.push_back(e);
                end
                m_squash  = 0;
                m_pend    = e_req;
                m_pend_pc = m_pc;
                if (e_req) m_pc = m_pc + 32'd4;
            end
        end
    end

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
        tick();
        #3;
        chk("rst req", {31'b0, req}, 32'd0);
        chk("rst addr", addr, 32'h0);
        chk("rst valid", {31'b0, valid}, 32'd0);
        chk("rst instr", instr, 32'h0);
        chk("rst instr_pc", instr_pc, 32'h0);
        chk("rst opcode", {25'b0, opcode}, 32'h0);
        chk("wrap rst addr", addr2, 32'hFFFF_FFF8);

        tick(); rst = 1'b0;                         // cycle 0
        #3;
        chk("c0 req", {31'b0, req}, 32'd1);
        chk("c0 addr", addr, 32'h0);
        tick(); #3;                                 // cycle 1
        chk("c1 valid", {31'b0, valid}, 32'd0);
        tick(); #3;                                 // cycle 2
        chk("c2 valid", {31'b0, valid}, 32'd1);
        chk("c2 pc", instr_pc, 32'h0);
        chk("c2 instr", instr, 32'h0000_0013);
        chk("wrap c2 pc", instr_pc2, 32'hFFFF_FFF8);

        tick(); ready = 1'b0; #3;                   // cycle 3
        chk("wrap c3 pc", instr_pc2, 32'hFFFF_FFFC);
        for (int k = 3; k < 8; k++) begin
            if (k > 3) begin tick(); #3; end
            chk("bp valid", {31'b0, valid}, 32'd1);
            chk("bp pc", instr_pc, 32'h4);
            chk("bp instr", instr, 32'h0040_0013);
            chk("bp req", {31'b0, req}, 32'd0);
            if (k == 4) begin
                chk("wrap c4 valid", {31'b0, valid2}, 32'd1);
                chk("wrap c4 pc", instr_pc2, 32'h0);
            end
        end
        tick(); ready = 1'b1; #3;                   // cycle 8
        chk("rel pc4", instr_pc, 32'h4);
        tick(); #3;
        chk("rel pc8", instr_pc, 32'h8);
        tick(); #3;
        chk("rel pc12", instr_pc, 32'hC);

        tick(); redirect = 1'b1; redirect_pc = 32'h0000_0103; #3;   // cycle 11
        chk("redir valid", {31'b0, valid}, 32'd0);
        chk("redir req", {31'b0, req}, 32'd0);
        tick(); redirect = 1'b0; #3;
        chk("redir+1 req", {31'b0, req}, 32'd1);
        chk("redir+1 addr", addr, 32'h100);
        chk("redir+1 valid", {31'b0, valid}, 32'd0);
        tick(); #3;
        chk("redir+2 valid", {31'b0, valid}, 32'd0);
        tick(); ready = 1'b0; #3;                   // cycle 14
        chk("redir+3 valid", {31'b0, valid}, 32'd1);
        chk("redir+3 pc", instr_pc, 32'h100);
        chk("redir+3 instr", instr, 32'h1000_0013);

        tick(); ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; #3;  // count=2
        chk("redir pop valid", {31'b0, valid}, 32'd0);
        tick(); redirect = 1'b0; #3;
        chk("flush valid", {31'b0, valid}, 32'd0);
        chk("flush addr", addr, 32'h200);
        tick(); tick(); ready = 1'b0; #3;           // cycle 18
        chk("flush first pc", instr_pc, 32'h200);

        tick(); rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h300; ready = 1'b1; #3;
        chk("rst+redir valid", {31'b0, valid}, 32'd0);
        tick(); rst = 1'b0; redirect = 1'b0; #3;
        chk("post rst valid", {31'b0, valid}, 32'd0);
        chk("post rst addr", addr, 32'h0);
        tick(); tick(); #3;
        chk("post rst pc", instr_pc, 32'h0);

        for (int n = 0; n < 4000; n++) begin
            tick();
            rst      = ($urandom_range(0, 99) == 0);
            redirect = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
                1:       redirect_pc = $urandom() & 32'h0000_0FFF;
                default: redirect_pc = $urandom();
            endcase
            ready = ($urandom_range(0, 9) < 7);
        end
        tick(); rst = 1'b0; redirect = 1'b0; ready = 1'b1;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
